gsim_feeder: RTL and testbench

Operand sequencer and solution store for the GSIM Gauss-Seidel solver. Holds the N-entry solution vector x and the right-hand side b, and issues one row update per slot to the downstream 3-cycle PE as {b_i, x[i±1], x[i±2], x[i±3]}. It captures the PE result back into x after the fixed PE latency and, after ITER sweeps, streams the final x out. It drives the PE's inputs and consumes its output, so it closes the loop around the PE.

---
 rtl/gsim_pkg.sv | 34 +++
 rtl/gsim_inflight_pipe.sv | 69 ++++++
 rtl/gsim_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_gsim_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// gsim_pkg: shared types and constants for the GSIM operand feeder.
// Build option GSIM_INTERLOCK_EN turns on the read-after-write issue stall.
package gsim_pkg;

    localparam int N_DEF      = 16;
    localparam int ITER_DEF   = 8;
    localparam int PE_LAT_DEF = 3;

    // Each row reads this many neighbours on either side.
    localparam int REACH = 3;

`ifdef GSIM_INTERLOCK_EN
    localparam bit INTERLOCK_EN = 1'b1;
`else
    localparam bit INTERLOCK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        OUTPUT
    } state_t;

    typedef logic signed [31:0] x_t;
    typedef logic signed [15:0] b_t;

    // Index width for an n-entry vector (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gsim_inflight_pipe.sv
// gsim_inflight_pipe: tracks rows in flight through the PE and flags
// issues whose lower neighbours have not yet returned.
module gsim_inflight_pipe
    import gsim_pkg::*;
#(
    parameter int DEPTH = PE_LAT_DEF,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic [IDX_W-1:0] q_idx,
    output logic             tail_valid,
    output logic [IDX_W-1:0] tail_idx,
    output logic             hazard,
    output logic             pending
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [IDX_W-1:0] idx_d [DEPTH];
    logic             hit;

    // Advance every cycle; a new issue enters at stage 0.
    always_comb begin
        vld_d[0] = push;
        idx_d[0] = push ? push_idx : '0;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
    end

    // Pipe state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign tail_valid = vld_q[DEPTH-1];
    assign tail_idx   = idx_q[DEPTH-1];

    // Match non-tail entries holding one of the rows just below q_idx;
    // the tail is excluded because its result is forwarded this cycle.
    always_comb begin
        hit     = 1'b0;
        pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (vld_q[k]) begin
                pending = 1'b1;
                if ((idx_q[k] < q_idx) &&
                    ((q_idx - idx_q[k]) <= IDX_W'(REACH))) begin
                    hit = 1'b1;
                end
            end
        end
        hazard = INTERLOCK_EN && hit;
    end

endmodule

// File: rtl/gsim_feeder.sv
// gsim_feeder: GSIM operand sequencer and solution store around the PE.
// Build option GSIM_INTERLOCK_EN (see gsim_pkg) selects Gauss-Seidel stalls.
module gsim_feeder
    import gsim_pkg::*;
#(
    parameter  int N      = N_DEF,
    parameter  int ITER   = ITER_DEF,
    parameter  int PE_LAT = PE_LAT_DEF,
    localparam int IDX_W  = idx_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               b_valid,
    input  logic signed [15:0] b_in,
    output logic signed [15:0] pe_b,
    output logic signed [31:0] pe_in_1,
    output logic signed [31:0] pe_in_2,
    output logic signed [31:0] pe_in_3,
    output logic signed [31:0] pe_in_4,
    output logic signed [31:0] pe_in_5,
    output logic signed [31:0] pe_in_6,
    input  logic signed [31:0] pe_out,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    output logic signed [31:0] x_out,
    output logic               busy,
    output logic               done
);

    localparam int               SW_W       = idx_w(ITER);
    localparam int               AW         = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [SW_W-1:0]  LAST_SWEEP = SW_W'(ITER - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
    logic [SW_W-1:0]  sweep_q, sweep_d;
    logic             done_q, done_d;

    x_t x_q [N];
    x_t x_d [N];
    b_t b_q [N];
    b_t b_d [N];

    // Operand slots: i-1, i+1, i-2, i+2, i-3, i+3.
    b_t pe_b_q, pe_b_d;
    x_t opr_q [6];
    x_t opr_d [6];
    x_t nbr   [6];

    logic [AW-1:0]    base, lo, hi;
    logic             issue;
    logic             tail_valid;
    logic [IDX_W-1:0] tail_idx;
    logic             hazard;
    logic             pending;

    gsim_inflight_pipe #(
        .DEPTH (PE_LAT),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .push       (issue),
        .push_idx   (idx_q),
        .q_idx      (idx_q),
        .tail_valid (tail_valid),
        .tail_idx   (tail_idx),
        .hazard     (hazard),
        .pending    (pending)
    );

    // Neighbour reads: off-end rows read 0, the row returning now is forwarded.
    always_comb begin
        base = {1'b0, idx_q};
        lo   = '0;
        hi   = '0;
        for (int k = 0; k < 6; k++) begin
            nbr[k] = '0;
        end
        for (int k = 1; k <= REACH; k++) begin
            lo = base - AW'(k);
            hi = base + AW'(k);
            if (base >= AW'(k)) begin
                nbr[2*k-2] = (tail_valid && tail_idx == lo[IDX_W-1:0])
                           ? pe_out : x_q[lo[IDX_W-1:0]];
            end
            if (hi <= AW'(N - 1)) begin
                nbr[2*k-1] = (tail_valid && tail_idx == hi[IDX_W-1:0])
                           ? pe_out : x_q[hi[IDX_W-1:0]];
            end
        end
    end

    // Sequencer: load b, sweep the rows, drain the PE, stream x out.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        idx_d      = idx_q;
        sweep_d    = sweep_q;
        out_cnt_d  = out_cnt_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        x_d        = x_q;
        b_d        = b_q;
        if (tail_valid) begin
            x_d[tail_idx] = pe_out;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d        = '{default: '0};
                    load_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (b_valid) begin
                    b_d[load_cnt_q] = b_in;
                    load_cnt_d      = load_cnt_q + IDX_W'(1);
                    if (load_cnt_q == LAST_IDX) begin
                        idx_d   = '0;
                        sweep_d = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!hazard) begin
                    issue = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        if (sweep_q == LAST_SWEEP) begin
                            state_d = DRAIN;
                        end else begin
                            sweep_d = sweep_q + SW_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    out_cnt_d = '0;
                    state_d   = OUTPUT;
                end
            end
            OUTPUT: begin
                out_cnt_d = out_cnt_q + IDX_W'(1);
                if (out_cnt_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issued operands are registered; idle slots present zeros.
    always_comb begin
        pe_b_d = '0;
        for (int k = 0; k < 6; k++) begin
            opr_d[k] = '0;
        end
        if (issue) begin
            pe_b_d = b_q[idx_q];
            for (int k = 0; k < 6; k++) begin
                opr_d[k] = nbr[k];
            end
        end
    end

    // State, storage and operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            idx_q      <= '0;
            out_cnt_q  <= '0;
            sweep_q    <= '0;
            done_q     <= 1'b0;
            pe_b_q     <= '0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k < 6; k++) begin
                opr_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            idx_q      <= idx_d;
            out_cnt_q  <= out_cnt_d;
            sweep_q    <= sweep_d;
            done_q     <= done_d;
            pe_b_q     <= pe_b_d;
            x_q        <= x_d;
            b_q        <= b_d;
            opr_q      <= opr_d;
        end
    end

    assign pe_b      = pe_b_q;
    assign pe_in_1   = opr_q[0];
    assign pe_in_2   = opr_q[1];
    assign pe_in_3   = opr_q[2];
    assign pe_in_4   = opr_q[3];
    assign pe_in_5   = opr_q[4];
    assign pe_in_6   = opr_q[5];
    assign out_valid = (state_q == OUTPUT);
    assign out_idx   = out_valid ? out_cnt_q : '0;
    assign x_out     = out_valid ? x_q[out_cnt_q] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_gsim_feeder.sv
// tb_gsim_feeder: directed runs checked cycle by cycle against a
// schedule/value model of Gauss-Seidel (or chaotic) row updates.
module tb_gsim_feeder;

    localparam int N      = 16;
    localparam int ITER   = 2;
    localparam int PE_LAT = 3;
    localparam int MAXC   = 160;
`ifdef GSIM_INTERLOCK_EN
    localparam bit ILK = 1'b1;
`else
    localparam bit ILK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               b_valid = 1'b0;
    logic signed [15:0] b_in = '0;
    logic signed [31:0] pe_out = '0;
    logic signed [15:0] pe_b;
    logic signed [31:0] pe_in_1, pe_in_2, pe_in_3;
    logic signed [31:0] pe_in_4, pe_in_5, pe_in_6;
    logic               out_valid;
    logic [3:0]         out_idx;
    logic signed [31:0] x_out;
    logic               busy;
    logic               done;

    gsim_feeder #(.N(N), .ITER(ITER), .PE_LAT(PE_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .b_valid   (b_valid),
        .b_in      (b_in),
        .pe_b      (pe_b),
        .pe_in_1   (pe_in_1),
        .pe_in_2   (pe_in_2),
        .pe_in_3   (pe_in_3),
        .pe_in_4   (pe_in_4),
        .pe_in_5   (pe_in_5),
        .pe_in_6   (pe_in_6),
        .pe_out    (pe_out),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int phase = 0;
    int rel = 0;

    int e_b    [MAXC];
    int e_in   [MAXC][6];
    int drv    [MAXC];
    int e_ov   [MAXC];
    int e_oi   [MAXC];
    int e_ox   [MAXC];
    int e_busy [MAXC];
    int e_done [MAXC];
    int xm [N];
    int bv [N];
    int m_last, m_e, m_end, m_t1, m_t15;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (phase %0d rel %0d)",
                     nm, act, exp, phase, rel);
        end
    endtask

    function automatic int opv(input int j);
        return (j >= 0 && j < N) ? xm[j] : 0;
    endfunction

    function automatic int pe_fn(input int mode, input int i, input int s);
        case (mode)
            0:       return 100;
            1:       return 7 * i;
            default: return s * 100000 - i * 37 - 5;
        endcase
    endfunction

    // Build the expected trace: issue times from the hazard rule, operand
    // values from results that have returned (or are returning) by then.
    task automatic build_model(input int mode);
        int tq[$];
        int iq[$];
        int rq[$];
        int lastiss[N];
        int lt, ptr, t, r;
        for (int c = 0; c < MAXC; c++) begin
            e_b[c] = 0;
            for (int k = 0; k < 6; k++) e_in[c][k] = 0;
            drv[c] = 32'h5A5A0000 + c * 13;
            e_ov[c] = 0; e_oi[c] = 0; e_ox[c] = 0;
            e_busy[c] = 1; e_done[c] = 0;
        end
        for (int j = 0; j < N; j++) begin
            bv[j] = (mode == 0) ? j : j * 1237 - 9000 - mode * 11;
            lastiss[j] = -100;
            xm[j] = 0;
        end
        lt = -1;
        ptr = 0;
        for (int s = 0; s < ITER; s++) begin
            for (int i = 0; i < N; i++) begin
                t = lt + 1;
                if (ILK) begin
                    for (int k = 1; k <= 3; k++) begin
                        if (i - k >= 0 && lastiss[i-k] + PE_LAT > t)
                            t = lastiss[i-k] + PE_LAT;
                    end
                end
                while (ptr < tq.size() && tq[ptr] + PE_LAT <= t) begin
                    xm[iq[ptr]] = rq[ptr];
                    ptr++;
                end
                e_b[t+1] = bv[i];
                for (int k = 1; k <= 3; k++) begin
                    e_in[t+1][2*k-2] = opv(i - k);
                    e_in[t+1][2*k-1] = opv(i + k);
                end
                r = pe_fn(mode, i, s);
                drv[t+PE_LAT] = r;
                tq.push_back(t);
                iq.push_back(i);
                rq.push_back(r);
                if (s == 0 && i == 1) m_t1 = t;
                if (s == 0 && i == N - 1) m_t15 = t;
                lastiss[i] = t;
                lt = t;
            end
        end
        while (ptr < tq.size()) begin
            xm[iq[ptr]] = rq[ptr];
            ptr++;
        end
        m_last = lt;
        m_e = lt + PE_LAT + 1;
        for (int k = 0; k < N; k++) begin
            e_ov[m_e+k] = 1;
            e_oi[m_e+k] = k;
            e_ox[m_e+k] = xm[k];
        end
        for (int c = m_e + N; c < MAXC; c++) e_busy[c] = 0;
        e_done[m_e+N] = 1;
        m_end = m_e + N + 1;
    endtask

    function automatic logic signed [31:0] pin(input int k);
        case (k)
            0:       return pe_in_1;
            1:       return pe_in_2;
            2:       return pe_in_3;
            3:       return pe_in_4;
            4:       return pe_in_5;
            default: return pe_in_6;
        endcase
    endfunction

    // Compare process: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (phase == 1) begin
            chk("busy_load", busy, 1);
            chk("pe_b_load", pe_b, 0);
            chk("out_valid_load", out_valid, 0);
        end else if (phase == 2) begin
            chk("pe_b", pe_b, e_b[rel]);
            for (int k = 0; k < 6; k++)
                chk($sformatf("pe_in_%0d", k + 1), pin(k), e_in[rel][k]);
            chk("out_valid", out_valid, e_ov[rel]);
            chk("out_idx", out_idx, e_oi[rel]);
            chk("x_out", x_out, e_ox[rel]);
            chk("busy", busy, e_busy[rel]);
            chk("done", done, e_done[rel]);
        end else if (phase == 3) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_x_out", x_out, 0);
            chk("rst_pe_b", pe_b, 0);
            for (int k = 0; k < 6; k++)
                chk($sformatf("rst_pe_in_%0d", k + 1), pin(k), 0);
        end
    end

    task automatic do_run(input int mode, input bit disturb, input int abort_at);
        build_model(mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        phase = 1;
        for (int k = 0; k < N; k++) begin
            if (k == 5) begin
                b_valid = 1'b0;
                tick();
            end
            b_valid = 1'b1;
            b_in = 16'(bv[k]);
            tick();
        end
        b_valid = 1'b0;
        b_in = '0;
        phase = 2;
        for (int r = 0; r <= m_end; r++) begin
            rel = r;
            pe_out = drv[r];
            start = (disturb && r == 5);
            b_valid = (disturb && r == m_e + 3);
            b_in = b_valid ? 16'sh7fff : 16'sh0;
            if (r == abort_at) begin
                reset = 1'b1;
                phase = 3;
                tick();
                tick();
                reset = 1'b0;
                tick();
                phase = 0;
                return;
            end
            tick();
        end
        start = 1'b0;
        b_valid = 1'b0;
        pe_out = '0;
        phase = 3;
        tick();
        phase = 0;
    endtask

    initial begin
        phase = 3;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        phase = 0;

        do_run(0, 1'b0, -1);
        chk("pin_first_b", e_b[1], 0);
        chk("pin_first_in1", e_in[1][0], 0);
        chk("pin_first_in2", e_in[1][1], 0);
        chk("pin_t1", m_t1, ILK ? 3 : 1);
        chk("pin_fwd_in1", e_in[m_t1+1][0], ILK ? 100 : 0);
        chk("pin_fwd_in3", e_in[m_t1+1][2], 0);
        chk("pin_fwd_in5", e_in[m_t1+1][4], 0);
        chk("pin_i15_in1", e_in[m_t15+1][0], ILK ? 100 : 0);
        chk("pin_i15_in2", e_in[m_t15+1][1], 0);
        chk("pin_i15_in4", e_in[m_t15+1][3], 0);
        chk("pin_i15_in6", e_in[m_t15+1][5], 0);
        chk("pin_last_issue", m_last, ILK ? 91 : 31);
        chk("pin_out_start", m_e, ILK ? 95 : 35);

        do_run(1, 1'b0, -1);
        chk("pin_x0", e_ox[m_e], 0);
        chk("pin_x5", e_ox[m_e+5], 35);
        chk("pin_x15", e_ox[m_e+15], 105);
        chk("pin_done", e_done[m_e+N], 1);

        do_run(2, 1'b0, 10);
        do_run(2, 1'b0, -1);
        do_run(1, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
